// File: rtl/order_matcher_if.sv
// order_matcher_if: quote inputs, trade handshake and statistics outputs of the order matcher
interface order_matcher_if #(
  parameter int COUNT_W    = 16,
  parameter int NOTIONAL_W = 24
);
  logic [7:0]            buy_price;
  logic [7:0]            sell_price;
  logic                  trade_ready;
  logic                  trade_valid;
  logic [7:0]            trade_price;
  logic [COUNT_W-1:0]    trade_count;
  logic [COUNT_W-1:0]    drop_count;
  logic [NOTIONAL_W-1:0] notional;
  logic [7:0]            spread;
  logic                  crossed;
  logic                  busy;
  modport master (
    output buy_price, sell_price, trade_ready,
    input  trade_valid, trade_price, trade_count, drop_count, notional, spread, crossed, busy
  );
  modport slave (
    input  buy_price, sell_price, trade_ready,
    output trade_valid, trade_price, trade_count, drop_count, notional, spread, crossed, busy
  );
endinterface

// File: rtl/order_matcher.sv
// order_matcher: filters stable quotes, trades one unit at the ask on a crossed book, keeps statistics
module order_matcher #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 16,
  parameter int NOTIONAL_W    = 24
) (
  input logic            clk,
  input logic            reset,
  order_matcher_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EVAL  = 2'd1;
  localparam logic [1:0] OFFER = 2'd2;
  logic [7:0]            r_bid, r_ask, r_cbid, r_cask, r_lbid, r_lask, r_wbid, r_wask;
  logic [7:0]            r_stab, r_price, r_spread;
  logic                  r_lvalid, r_valid, r_crossed;
  logic [1:0]            r_state;
  logic [COUNT_W-1:0]    r_tcnt, r_dcnt;
  logic [NOTIONAL_W-1:0] r_notional;
  logic                  w_same, w_event, w_cross;
  assign w_same  = {r_bid, r_ask} == {r_cbid, r_cask};
  assign w_event = (r_stab == 8'(STABLE_CYCLES)) && (!r_lvalid || {r_cbid, r_cask} != {r_lbid, r_lask});
  assign w_cross = r_wbid >= r_wask;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bid    <= '0;
      r_ask    <= '0;
      r_cbid   <= '0;
      r_cask   <= '0;
      r_stab   <= '0;
      r_lbid   <= '0;
      r_lask   <= '0;
      r_lvalid <= 1'b0;
    end else begin
      r_bid <= bus.buy_price;
      r_ask <= bus.sell_price;
      if (!w_same) begin
        r_cbid <= r_bid;
        r_cask <= r_ask;
        r_stab <= '0;
      end else if (r_stab != 8'(STABLE_CYCLES)) begin
        r_stab <= r_stab + 8'd1;
      end
      // every distinct quote fires once, even when it is dropped
      if (w_event) begin
        r_lbid   <= r_cbid;
        r_lask   <= r_cask;
        r_lvalid <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wbid     <= '0;
      r_wask     <= '0;
      r_valid    <= 1'b0;
      r_price    <= '0;
      r_spread   <= '0;
      r_crossed  <= 1'b0;
      r_tcnt     <= '0;
      r_dcnt     <= '0;
      r_notional <= '0;
    end else begin
      if (w_event && r_state != IDLE && r_dcnt != '1) r_dcnt <= r_dcnt + 1'b1;
      case (r_state)
        IDLE: if (w_event) begin
          r_wbid  <= r_cbid;
          r_wask  <= r_cask;
          r_state <= EVAL;
        end
        EVAL: begin
          r_crossed <= w_cross;
          r_spread  <= r_wask > r_wbid ? r_wask - r_wbid : 8'd0;
          r_state   <= w_cross ? OFFER : IDLE;
          if (w_cross) begin
            r_price <= r_wask;
            r_valid <= 1'b1;
          end
        end
        OFFER: if (bus.trade_ready) begin
          r_valid    <= 1'b0;
          r_tcnt     <= r_tcnt == '1 ? r_tcnt : r_tcnt + 1'b1;
          r_notional <= r_notional + NOTIONAL_W'(r_price);
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.trade_valid = r_valid;
  assign bus.trade_price = r_price;
  assign bus.trade_count = r_tcnt;
  assign bus.drop_count  = r_dcnt;
  assign bus.notional    = r_notional;
  assign bus.spread      = r_spread;
  assign bus.crossed     = r_crossed;
  assign bus.busy        = r_state != IDLE;
endmodule

// File: tb/tb_order_matcher.sv
// tb_order_matcher: directed checks of quote filtering, trading, drops, async reset and saturation
module tb_order_matcher;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  order_matcher_if #(.COUNT_W(16), .NOTIONAL_W(24)) m ();
  order_matcher_if #(.COUNT_W(2), .NOTIONAL_W(8)) n ();
  order_matcher #(.STABLE_CYCLES(4), .COUNT_W(16), .NOTIONAL_W(24)) u_dut (
    .clk(clk), .reset(reset), .bus(m.slave)
  );
  order_matcher #(.STABLE_CYCLES(4), .COUNT_W(2), .NOTIONAL_W(8)) u_sat (
    .clk(clk), .reset(reset), .bus(n.slave)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int c);
    repeat (c) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    m.buy_price = 8'd60; m.sell_price = 8'd70; m.trade_ready = 1'b0;
    n.buy_price = 8'd255; n.sell_price = 8'd1; n.trade_ready = 1'b1;
    cyc(2);
    chk("rst_valid", m.trade_valid, 0);
    chk("rst_count", m.trade_count, 0);
    chk("rst_notional", m.notional, 0);
    chk("rst_busy", m.busy, 0);
    reset = 1'b0;
    cyc(8);
    chk("nc_crossed", m.crossed, 0);
    chk("nc_spread", m.spread, 10);
    chk("nc_valid", m.trade_valid, 0);
    chk("nc_count", m.trade_count, 0);
    m.buy_price = 8'd80; m.sell_price = 8'd60; m.trade_ready = 1'b1;
    cyc(7);
    chk("x_valid_e6", m.trade_valid, 0);
    chk("x_busy_e6", m.busy, 1);
    cyc(1);
    chk("x_valid_e7", m.trade_valid, 1);
    chk("x_price_e7", m.trade_price, 60);
    chk("x_crossed", m.crossed, 1);
    chk("x_spread", m.spread, 0);
    cyc(1);
    chk("x_valid_e8", m.trade_valid, 0);
    chk("x_count", m.trade_count, 1);
    chk("x_notional", m.notional, 60);
    reset = 1'b1; m.trade_ready = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(8);
    chk("hold_valid0", m.trade_valid, 1);
    chk("hold_price0", m.trade_price, 60);
    m.buy_price = 8'd81; m.sell_price = 8'd55;
    cyc(20);
    chk("hold_valid", m.trade_valid, 1);
    chk("hold_price", m.trade_price, 60);
    chk("hold_drop", m.drop_count, 1);
    chk("hold_count0", m.trade_count, 0);
    m.trade_ready = 1'b1;
    cyc(1);
    chk("hold_valid_done", m.trade_valid, 0);
    chk("hold_count", m.trade_count, 1);
    chk("hold_notional", m.notional, 60);
    cyc(15);
    chk("no_retrade_count", m.trade_count, 1);
    chk("no_retrade_busy", m.busy, 0);
    for (int k = 0; k < 8; k++) begin
      m.buy_price = k[0] ? 8'd30 : 8'd10;
      m.sell_price = k[0] ? 8'd40 : 8'd20;
      cyc(3);
      chk("glitch_busy", m.busy, 0);
    end
    chk("glitch_count", m.trade_count, 1);
    chk("glitch_drop", m.drop_count, 1);
    m.buy_price = 8'd70; m.sell_price = 8'd70;
    cyc(8);
    chk("eq_valid", m.trade_valid, 1);
    chk("eq_price", m.trade_price, 70);
    cyc(1);
    chk("eq_count", m.trade_count, 2);
    chk("eq_notional", m.notional, 130);
    reset = 1'b1; m.buy_price = 8'd80; m.sell_price = 8'd60;
    cyc(1);
    reset = 1'b0;
    cyc(9);
    chk("rep_count0", m.trade_count, 1);
    chk("rep_notional0", m.notional, 60);
    m.buy_price = 8'd20; m.sell_price = 8'd30;
    cyc(2);
    m.buy_price = 8'd80; m.sell_price = 8'd60;
    cyc(15);
    chk("rep_count", m.trade_count, 1);
    chk("rep_busy", m.busy, 0);
    chk("rep_drop", m.drop_count, 0);
    m.buy_price = 8'd79; m.sell_price = 8'd61;
    cyc(8);
    chk("new_valid", m.trade_valid, 1);
    chk("new_price", m.trade_price, 61);
    cyc(1);
    chk("new_count", m.trade_count, 2);
    chk("new_notional", m.notional, 121);
    m.trade_ready = 1'b0; m.buy_price = 8'd90; m.sell_price = 8'd50;
    cyc(8);
    chk("ar_valid_pre", m.trade_valid, 1);
    chk("ar_busy_pre", m.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", m.trade_valid, 0);
    chk("ar_price", m.trade_price, 0);
    chk("ar_count", m.trade_count, 0);
    chk("ar_drop", m.drop_count, 0);
    chk("ar_notional", m.notional, 0);
    chk("ar_spread", m.spread, 0);
    chk("ar_crossed", m.crossed, 0);
    chk("ar_busy", m.busy, 0);
    @(negedge clk) reset = 1'b0;
    cyc(8);
    chk("ar_revalid", m.trade_valid, 1);
    chk("ar_reprice", m.trade_price, 50);
    m.trade_ready = 1'b1;
    cyc(1);
    chk("ar_recount", m.trade_count, 1);
    chk("ar_renotional", m.notional, 50);
    reset = 1'b1; n.buy_price = 8'd255; n.sell_price = 8'd1;
    cyc(1);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      n.sell_price = 8'(k);
      cyc(9);
      chk("sat_count", n.trade_count, k < 3 ? k : 3);
    end
    reset = 1'b1; n.buy_price = 8'd250; n.sell_price = 8'd200;
    cyc(1);
    reset = 1'b0;
    cyc(9);
    chk("wrap_n1", n.notional, 200);
    n.buy_price = 8'd150; n.sell_price = 8'd100;
    cyc(9);
    chk("wrap_n2", n.notional, 44);
    chk("wrap_count", n.trade_count, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/order_matcher.md
Name: order_matcher

Overview:
- Consumer end of the price feed: takes the simulated buy_price (bid) and sell_price (ask) quote pair and detects each new, stable quote.
- When bid >= ask (crossed book), issues a one-unit trade at the ask price over a valid/ready handshake.
- Keeps trade, drop and notional statistics plus the current spread for display and downstream logging.

Parameters:
- STABLE_CYCLES, 4: consecutive clk cycles a quote pair must hold unchanged before it is accepted (legal range 1..255).
- COUNT_W, 16: width of trade_count and drop_count.
- NOTIONAL_W, 24: width of the notional accumulator.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-high reset; clears all state.
- buy_price  input  8  bid quote; may change at any clk edge.
- sell_price  input  8  ask quote; may change at any clk edge.
- trade_ready  input  1  downstream accepts the offered trade.
- trade_valid  output  1  trade offered.
- trade_price  output  8  price of the offered trade (= accepted ask).
- trade_count  output  COUNT_W  completed trades, saturating.
- drop_count  output  COUNT_W  quotes discarded while busy, saturating.
- notional  output  NOTIONAL_W  sum of completed trade prices, wraps modulo 2^NOTIONAL_W.
- spread  output  8  ask-bid of the last evaluated quote; 0 if crossed.
- crossed  output  1  last evaluated quote had bid >= ask.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - All outputs 0; FSM to IDLE.
  - Input regs, candidate, stability counter and last-accepted pair cleared; the last-accepted flag is cleared so the first stable quote is always accepted.
- Input stage: bid/ask registered every clk (1 cycle). Call the first edge that samples a new value edge 0.
- Stability filter:
  - If the registered pair differs from the candidate: the candidate loads it and stab is set to 0.
  - Otherwise stab increments, saturating at STABLE_CYCLES.
  - Any change restarts the count, so glitches shorter than STABLE_CYCLES are never accepted.
- quote_event is true when stab == STABLE_CYCLES and (no quote accepted yet, or candidate != last-accepted pair).
  - On every quote_event edge, last-accepted <= candidate, so each distinct quote fires once.
  - A repeat of the last-accepted pair never fires.
- FSM states: IDLE, EVAL, OFFER.
  - IDLE: on quote_event, latch bid/ask into working regs and go to EVAL.
  - EVAL (exactly 1 cycle):
    - crossed <= (bid >= ask).
    - spread <= ask-bid if ask > bid, else 0.
    - If crossed: trade_price <= ask, trade_valid <= 1, go to OFFER. Otherwise go to IDLE.
  - OFFER: trade_valid and trade_price are held stable until an edge with trade_ready=1. On that edge:
    - trade_valid <= 0.
    - trade_count +1, saturating at all-ones.
    - notional += trade_price, zero-extended, wrapping.
    - Go to IDLE.
  - trade_ready already high when valid rises: the handshake completes on the next edge, so valid is high for 1 cycle.
  - trade_ready while not valid: ignored.
- Drops: a quote_event while the FSM is in EVAL or OFFER discards the quote.
  - drop_count +1, saturating.
  - last-accepted is still updated.
  - The working regs and the outstanding trade are unaffected.
- Latency: trade_valid is high after edge STABLE_CYCLES+3 (edge 7 at default). A non-crossed quote updates spread/crossed after edge STABLE_CYCLES+3.
- Arithmetic: all comparisons are unsigned 8-bit; spread never underflows. busy = (state != IDLE).

Test Plan:
- Reset, then bid=60 ask=70 held -> after edge 7: crossed=0, spread=10, trade_valid stays 0, trade_count=0.
- bid=80 ask=60 held, trade_ready=1 -> trade_valid high exactly 1 cycle after edge 7 with trade_price=60; then trade_count=1, notional=60, spread=0, crossed=1.
- Cross with trade_ready=0 for 20 cycles, while the quote changes to bid=81 ask=55 and holds -> trade_valid/trade_price=60 held throughout, drop_count=1. Raise ready -> trade_count=1, notional=60, no second trade from the dropped quote.
- Quote toggles every 3 cycles (STABLE_CYCLES=4) -> no EVAL ever; busy=0, counters unchanged. Then hold bid=70 ask=70 -> trade at 70 (equality crosses).
- Same crossed quote re-held after a completed trade -> no second trade. Change to bid=79 ask=61 -> trade at 61, notional=121.
- Assert reset while in OFFER -> all outputs 0 immediately without a clock edge. Release with the previous quote still applied -> it is re-accepted and traded again.
- Saturation: with COUNT_W=2, complete 5 trades -> trade_count=3. Notional wraps with NOTIONAL_W=8: trades at 200 and 100 -> notional=44.
